mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one read port and one write port of the single-cycle memory (combinational read, registered write) between NUM_REQ requesters, e.g. fetch and load/store.
- Round-robin arbitration with a valid/ready request handshake.
- One outstanding transaction at a time; the response is registered and held until the owner accepts it.
- Sits between the pipeline stages and the memory instance; drives the memory's read_enable/read_addr/write_enable/write_addr/write_data and samples read_data.

Parameters:
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 32, address width, passed through unchanged
- NUM_REQ, 2, number of requesters (>=2); index 0 has first priority after reset

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- req_valid  input  [NUM_REQ-1:0]  requester i presents a transaction
- req_we  input  [NUM_REQ-1:0]  1 = write, 0 = read
- req_addr  input  [ADDR_WIDTH-1:0] x NUM_REQ (unpacked)  transaction address
- req_wdata  input  [DATA_WIDTH-1:0] x NUM_REQ (unpacked)  write data
- req_ready  output  [NUM_REQ-1:0]  combinational; one-hot or zero; transaction accepted this cycle
- resp_valid  output  [NUM_REQ-1:0]  registered; one-hot or zero; response for owner i
- resp_rdata  output  [DATA_WIDTH-1:0]  registered read data; 0 for write responses
- resp_ready  input  [NUM_REQ-1:0]  requester i consumes its response
- mem_read_enable  output  1  to memory read_enable[0]
- mem_read_addr  output  [ADDR_WIDTH-1:0]  to memory read_addr[0]
- mem_read_data  input  [DATA_WIDTH-1:0]  from memory read_data[0], same-cycle
- mem_write_enable  output  1  to memory write_enable[0]
- mem_write_addr  output  [ADDR_WIDTH-1:0]  to memory write_addr[0]
- mem_write_data  output  [DATA_WIDTH-1:0]  to memory write_data[0]

Behaviour:
- State: IDLE (no response held) or RESP (response held for owner o). Also rr_ptr (index width clog2(NUM_REQ)) and owner o.
- Slot free this cycle when: state == IDLE, or state == RESP && resp_ready[o].
- Grant, combinational: if the slot is free and any req_valid is set, g = first set req_valid scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. req_ready[g] = 1; all other bits 0. No grant, so req_ready = 0, when the slot is not free.
- Grant cycle memory drive, read: mem_read_enable = 1, mem_read_addr = req_addr[g].
- Grant cycle memory drive, write: mem_write_enable = 1, mem_write_addr = req_addr[g], mem_write_data = req_wdata[g].
- Never both enables in the same cycle. Without a grant, both enables are 0 and all mem addr/data outputs are 0.
- Posedge after a grant:
  - state <= RESP, o <= g, resp_valid <= one-hot(g)
  - resp_rdata <= mem_read_data for a read, 0 for a write
  - rr_ptr <= (g + 1) mod NUM_REQ
- Latency: response visible exactly 1 cycle after acceptance, then held stable until resp_ready[o].
- Response consumed with no new grant: state <= IDLE, resp_valid <= 0, resp_rdata unchanged.
- Simultaneous drain and grant: the old response retires and the new one loads in the same cycle. Back-to-back throughput is 1 transaction/cycle when resp_ready is held high.
- resp_ready bits of non-owners are ignored.
- The arbiter does not hold a request. A requester whose req_ready is 0 keeps req_valid and its fields stable until accepted. A dropped request is simply not served; no error is raised.
- Write-then-read to the same address on consecutive accepts returns the new data, because memory commits the write at the grant posedge.
- No address range checking; out-of-range behaviour is the memory's.
- rr_ptr advances only on a grant.
- Reset (any cycle, including RESP): state <= IDLE, rr_ptr <= 0, resp_valid <= 0, resp_rdata <= 0. A pending response is discarded. During reset, req_ready = 0 and both enables = 0.

Test Plan:
- Reset, then req_valid=01 read addr 5 (mem[5]=0xAB) -> req_ready=01 in cycle 0; resp_valid=01, resp_rdata=0xAB in cycle 1; with resp_ready=01, IDLE in cycle 2.
- Both requesters valid every cycle, resp_ready=11 -> grants alternate 0,1,0,1 across 4 consecutive cycles; each resp_valid follows its grant by 1 cycle.
- Owner 1 holds resp_ready=0 for 3 cycles while req 0 is valid -> req_ready=00 for those cycles; resp_valid=10 and resp_rdata stay stable; req 0 is granted in the same cycle resp_ready[1] rises.
- Req 0 writes 0x1234 to addr 9, req 1 reads addr 9 in the next accept -> mem_write_enable one cycle, then mem_read_enable; req 1 response = 0x1234; write response resp_rdata = 0.
- Reset asserted while in RESP with resp_valid=10 -> next cycle resp_valid=00, rr_ptr=0. With both requesters then valid, the first grant goes to index 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read port and one write port across NUM_REQ requesters.
// Latency: grant is combinational in the accept cycle; the response is registered and visible one cycle later.
// Backpressure: one response slot; while its owner withholds resp_ready, no new request is accepted.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr  [NUM_REQ],
  input  logic [DATA_WIDTH-1:0] req_wdata [NUM_REQ],
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   nxt_ptr;
  logic               gnt_any;
  logic               gnt_we;
  logic               slot_free;

  // The slot frees when nothing is held or the owner drains its response this cycle.
  // Reset blocks any acceptance so nothing reaches the memory during reset.
  assign slot_free = !reset && ((state == IDLE) || resp_ready[owner]);

  // Scan requesters starting at rr_ptr; the first valid one found wins.
  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(rr_ptr) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!gnt_any && req_valid[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    if (!slot_free) begin
      gnt_any = 1'b0;
      gnt_idx = '0;
    end
  end

  // One-hot ready towards the winner, nothing otherwise.
  always_comb begin
    req_ready = '0;
    if (gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign gnt_we  = req_we[gnt_idx];
  assign nxt_ptr = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Memory port drive: only the granted transaction touches the memory; idle buses are zero.
  always_comb begin
    mem_read_enable  = 1'b0;
    mem_read_addr    = '0;
    mem_write_enable = 1'b0;
    mem_write_addr   = '0;
    mem_write_data   = '0;
    if (gnt_any) begin
      if (gnt_we) begin
        mem_write_enable = 1'b1;
        mem_write_addr   = req_addr[gnt_idx];
        mem_write_data   = req_wdata[gnt_idx];
      end else begin
        mem_read_enable  = 1'b1;
        mem_read_addr    = req_addr[gnt_idx];
      end
    end
  end

  // Response slot FSM: a grant loads the slot (even while draining the old one), a drain empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else if (gnt_any) begin
      state      <= RESP;
      owner      <= gnt_idx;
      resp_valid <= req_ready;
      resp_rdata <= gnt_we ? '0 : mem_read_data;
      rr_ptr     <= nxt_ptr;
    end else if ((state == RESP) && resp_ready[owner]) begin
      state      <= IDLE;
      resp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory attached.
// Inputs change 1 time unit after posedge; combinational outputs are checked at negedge, registered ones after posedge.
// Expected values are hand-computed from the memory preload and the arbitration order.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_ready;
  logic        mem_read_enable;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_read_data;
  logic        mem_write_enable;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REQ(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_ready       (resp_ready),
    .mem_read_enable  (mem_read_enable),
    .mem_read_addr    (mem_read_addr),
    .mem_read_data    (mem_read_data),
    .mem_write_enable (mem_write_enable),
    .mem_write_addr   (mem_write_addr),
    .mem_write_data   (mem_write_data)
  );

  // Single-cycle memory: combinational read, write committed at posedge.
  assign mem_read_data = mem_read_enable ? mem[mem_read_addr[3:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_write_addr[3:0]] <= mem_write_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", req_ready); end
    checks++; if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin errors++; $display("FAIL rst_en got %b%b want 00", mem_read_enable, mem_write_enable); end
    step();
    reset = 1'b0;
    req_valid = 2'b00;
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got %b want 00", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
  endtask

  task automatic test_single_read();
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 32'd5; resp_ready = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL sr_ready got %b want 01", req_ready); end
    checks++; if (mem_read_enable !== 1'b1 || mem_read_addr !== 32'd5 || mem_write_enable !== 1'b0) begin errors++; $display("FAIL sr_mem got re=%b ra=%h we=%b want 1 5 0", mem_read_enable, mem_read_addr, mem_write_enable); end
    step();
    req_valid = 2'b00;
    checks++; if (resp_valid !== 2'b01 || resp_rdata !== 32'hAB) begin errors++; $display("FAIL sr_resp got %b %h want 01 000000ab", resp_valid, resp_rdata); end
    @(negedge clk);
    checks++; if (req_ready !== 2'b00 || mem_read_enable !== 1'b0 || mem_read_addr !== 32'h0) begin errors++; $display("FAIL sr_nogrant got %b %b %h want 00 0 0", req_ready, mem_read_enable, mem_read_addr); end
    step();
    checks++; if (resp_valid !== 2'b00 || resp_rdata !== 32'hAB) begin errors++; $display("FAIL sr_idle got %b %h want 00 000000ab", resp_valid, resp_rdata); end
  endtask

  // rr_ptr is 1 on entry (last grant was 0), so grants run 1,0,1,0.
  task automatic test_back_to_back();
    logic [1:0]  exp_g [4];
    logic [31:0] exp_d;
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
    req_valid = 2'b11; req_we = 2'b00; req_addr[0] = 32'd1; req_addr[1] = 32'd2; resp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (req_ready !== exp_g[i]) begin errors++; $display("FAIL b2b_grant%0d got %b want %b", i, req_ready, exp_g[i]); end
      step();
      exp_d = (exp_g[i] == 2'b01) ? 32'h11 : 32'h22;
      checks++; if (resp_valid !== exp_g[i] || resp_rdata !== exp_d) begin errors++; $display("FAIL b2b_resp%0d got %b %h want %b %h", i, resp_valid, resp_rdata, exp_g[i], exp_d); end
    end
    req_valid = 2'b00;
    step();
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b want 00", resp_valid); end
  endtask

  task automatic test_backpressure();
    req_valid = 2'b10; req_we = 2'b00; req_addr[0] = 32'd1; req_addr[1] = 32'd2; resp_ready = 2'b00;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant1 got %b want 10", req_ready); end
    step();
    req_valid = 2'b01;
    resp_ready = 2'b01;
    checks++; if (resp_valid !== 2'b10 || resp_rdata !== 32'h22) begin errors++; $display("FAIL bp_resp1 got %b %h want 10 00000022", resp_valid, resp_rdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (req_ready !== 2'b00 || mem_read_enable !== 1'b0) begin errors++; $display("FAIL bp_stall%0d got %b %b want 00 0", i, req_ready, mem_read_enable); end
      step();
      checks++; if (resp_valid !== 2'b10 || resp_rdata !== 32'h22) begin errors++; $display("FAIL bp_hold%0d got %b %h want 10 00000022", i, resp_valid, resp_rdata); end
    end
    resp_ready = 2'b10;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01 || mem_read_addr !== 32'd1) begin errors++; $display("FAIL bp_release got %b %h want 01 1", req_ready, mem_read_addr); end
    step();
    req_valid = 2'b00; resp_ready = 2'b01;
    checks++; if (resp_valid !== 2'b01 || resp_rdata !== 32'h11) begin errors++; $display("FAIL bp_resp0 got %b %h want 01 00000011", resp_valid, resp_rdata); end
    step();
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL bp_idle got %b want 00", resp_valid); end
  endtask

  task automatic test_write_then_read();
    req_valid = 2'b01; req_we = 2'b01; req_addr[0] = 32'd9; req_wdata[0] = 32'h1234; resp_ready = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_grant got %b want 01", req_ready); end
    checks++; if (mem_write_enable !== 1'b1 || mem_write_addr !== 32'd9 || mem_write_data !== 32'h1234 || mem_read_enable !== 1'b0) begin errors++; $display("FAIL wr_mem got we=%b wa=%h wd=%h re=%b want 1 9 1234 0", mem_write_enable, mem_write_addr, mem_write_data, mem_read_enable); end
    step();
    req_valid = 2'b10; req_we = 2'b00; req_addr[1] = 32'd9;
    checks++; if (resp_valid !== 2'b01 || resp_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp got %b %h want 01 0", resp_valid, resp_rdata); end
    @(negedge clk);
    checks++; if (req_ready !== 2'b10 || mem_read_enable !== 1'b1 || mem_read_addr !== 32'd9) begin errors++; $display("FAIL rd_grant got %b %b %h want 10 1 9", req_ready, mem_read_enable, mem_read_addr); end
    checks++; if (mem_write_enable !== 1'b0 || mem_write_data !== 32'h0) begin errors++; $display("FAIL rd_nowrite got %b %h want 0 0", mem_write_enable, mem_write_data); end
    step();
    req_valid = 2'b00;
    checks++; if (resp_valid !== 2'b10 || resp_rdata !== 32'h1234) begin errors++; $display("FAIL rd_resp got %b %h want 10 00001234", resp_valid, resp_rdata); end
    step();
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL wtr_idle got %b want 00", resp_valid); end
  endtask

  task automatic test_reset_in_resp();
    // Owner 1 holds a response when reset hits.
    req_valid = 2'b10; req_we = 2'b00; req_addr[0] = 32'd1; req_addr[1] = 32'd2; resp_ready = 2'b00;
    step();
    req_valid = 2'b11; reset = 1'b1;
    checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL rr_held got %b want 10", resp_valid); end
    @(negedge clk);
    checks++; if (req_ready !== 2'b00 || mem_read_enable !== 1'b0) begin errors++; $display("FAIL rr_during got %b %b want 00 0", req_ready, mem_read_enable); end
    step();
    reset = 1'b0; resp_ready = 2'b11;
    checks++; if (resp_valid !== 2'b00 || resp_rdata !== 32'h0) begin errors++; $display("FAIL rr_cleared got %b %h want 00 0", resp_valid, resp_rdata); end
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_first got %b want 01", req_ready); end
    step();
    req_valid = 2'b00; resp_ready = 2'b00;
    checks++; if (resp_valid !== 2'b01 || resp_rdata !== 32'h11) begin errors++; $display("FAIL rr_resp got %b %h want 01 00000011", resp_valid, resp_rdata); end
    // Owner 0 holds with rr_ptr at 1; reset must pull rr_ptr back to 0.
    step();
    reset = 1'b1;
    checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL rr_held0 got %b want 01", resp_valid); end
    step();
    reset = 1'b0; req_valid = 2'b11; resp_ready = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_ptr0 got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL rr_resp2 got %b want 01", resp_valid); end
    step();
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rr_idle got %b want 00", resp_valid); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] <= 32'hDEAD_0000 + i;
    mem[1] <= 32'h11;
    mem[2] <= 32'h22;
    mem[5] <= 32'hAB;
    reset = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; resp_ready = 2'b00;
    req_addr[0] = 32'h0; req_addr[1] = 32'h0;
    req_wdata[0] = 32'h0; req_wdata[1] = 32'h0;
    step();
    step();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_backpressure();
    test_write_then_read();
    test_reset_in_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
